// File: rtl/sobel_mdc_ctrl_pkg.sv
// sobel_mdc_ctrl_pkg: shared state encoding, frame-size type and default parameters for the Sobel MDC frame controller.
package sobel_mdc_ctrl_pkg;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_DIM_WIDTH      = 16;
  localparam int unsigned DEF_ID_WIDTH       = 8;
  localparam int unsigned DEF_CFG_CYCLES     = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1024;
  typedef enum logic [2:0] {IDLE, CONFIG, RUN, DRAIN, DONE} state_t;
  typedef logic [2*DEF_DIM_WIDTH-1:0] frame_size_t;
endpackage

// File: rtl/sobel_mdc_beat_cnt.sv
// sobel_mdc_beat_cnt: beat counter with clear/enable and a flag for the final beat of a target count.
module sobel_mdc_beat_cnt #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] target_i,
  output logic             last_o
);
  logic [WIDTH-1:0] cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt <= '0;
    else if (clear_i) cnt <= '0;
    else if (en_i) cnt <= cnt + 1'b1;
  assign last_o = cnt == target_i - 1'b1;
endmodule

// File: rtl/sobel_mdc_frame_ctrl.sv
// sobel_mdc_frame_ctrl: frame sequencer gating W*H beats into and out of the Sobel MDC kernel.
// Define SOBEL_MDC_CTRL_TIMEOUT_EN to add the DRAIN watchdog that aborts a stalled frame via error_o.
module sobel_mdc_frame_ctrl
  import sobel_mdc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int unsigned DIM_WIDTH      = DEF_DIM_WIDTH,
  parameter int unsigned ID_WIDTH       = DEF_ID_WIDTH,
  parameter int unsigned CFG_CYCLES     = DEF_CFG_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [DIM_WIDTH-1:0]  width_i,
  input  logic [DIM_WIDTH-1:0]  height_i,
  input  logic [ID_WIDTH-1:0]   cfg_id_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o,
  output logic [ID_WIDTH-1:0]   cfg_id_o,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] k_data_o,
  output logic                  k_valid_o,
  input  logic                  k_ready_i,
  input  logic [DATA_WIDTH-1:0] k_out_data_i,
  input  logic                  k_out_valid_i,
  output logic                  k_out_ready_o,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic                  out_last_o
);
  localparam int unsigned FW = 2 * DIM_WIDTH;
  localparam int unsigned CW = $clog2(CFG_CYCLES + 1);
  state_t state, state_nxt;
  logic [FW-1:0] total_q;
  logic [CW-1:0] cfg_cnt;
  logic in_act, out_act, in_hs, out_hs, in_last, out_last, frame_end, zero_frame, timeout, cnt_clr;
  assign zero_frame = width_i == '0 || height_i == '0;
  assign in_hs      = k_valid_o & k_ready_i;
  assign out_hs     = out_valid_o & out_ready_i;
  assign frame_end  = out_hs & out_last;
  assign cnt_clr    = clear_i | (state == IDLE);
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) state <= IDLE;
    else state <= state_nxt;
  // Frame end wins over input completion so a single-beat frame goes straight to DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_i) state_nxt = zero_frame ? DONE : CONFIG;
      CONFIG:  if (cfg_cnt == CW'(CFG_CYCLES - 1)) state_nxt = RUN;
      RUN:     if (frame_end) state_nxt = DONE;
               else if (in_hs && in_last) state_nxt = DRAIN;
      DRAIN:   if (frame_end) state_nxt = DONE;
               else if (timeout) state_nxt = IDLE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clear_i) state_nxt = IDLE;
  end
  always_comb begin
    busy_o  = state != IDLE;
    done_o  = state == DONE;
    in_act  = state == RUN;
    out_act = state == RUN || state == DRAIN;
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      total_q  <= '0;
      cfg_id_o <= '0;
    end else if (state == IDLE && start_i && !clear_i) begin
      total_q  <= FW'(width_i) * FW'(height_i);
      cfg_id_o <= cfg_id_i;
    end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cfg_cnt <= '0;
    else cfg_cnt <= state == CONFIG ? cfg_cnt + 1'b1 : '0;
  sobel_mdc_beat_cnt #(.WIDTH(FW)) u_in_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (cnt_clr),
    .en_i     (in_hs),
    .target_i (total_q),
    .last_o   (in_last)
  );
  sobel_mdc_beat_cnt #(.WIDTH(FW)) u_out_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (cnt_clr),
    .en_i     (out_hs),
    .target_i (total_q),
    .last_o   (out_last)
  );
  assign k_valid_o     = in_valid_i & in_act;
  assign in_ready_o    = k_ready_i & in_act;
  assign k_data_o      = in_data_i;
  assign out_valid_o   = k_out_valid_i & out_act;
  assign k_out_ready_o = out_ready_i & out_act;
  assign out_data_o    = k_out_data_i;
  assign out_last_o    = out_valid_o & out_last;
`ifdef SOBEL_MDC_CTRL_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wd_cnt;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) wd_cnt <= '0;
    else wd_cnt <= (state == DRAIN && !out_hs) ? wd_cnt + 1'b1 : '0;
  assign timeout = state == DRAIN && !out_hs && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  assign error_o = timeout;
endmodule

// File: tb/tb_sobel_mdc_frame_ctrl.sv
// tb_sobel_mdc_frame_ctrl: table-driven frame scenarios against a latency-configurable kernel stub.
module tb_sobel_mdc_frame_ctrl;
  localparam int CFG = 2;
  localparam logic [31:0] KEY = 32'hA5A5_0F0F;
  typedef struct {
    int w; int h; int id; int lat; bit bp; int clr_at; int stray_at; bit drop;
    int exp_in; int exp_out; int exp_done; int exp_busy;
  } vec_t;
  logic clk = 0, rst_ni = 0, clear_i = 0, start_i = 0;
  logic [15:0] width_i = 0, height_i = 0;
  logic [7:0] cfg_id_i = 0, cfg_id_o;
  logic busy_o, done_o, error_o;
  logic [31:0] in_data_i = 0, k_data_o, k_out_data_i, out_data_o;
  logic in_valid_i = 0, in_ready_o, k_valid_o, k_ready_i, k_out_valid_i, k_out_ready_o;
  logic out_valid_o, out_ready_i = 0, out_last_o;
  logic lat0 = 0, kv = 0, kr = 0;
  logic [31:0] kd = 0;
  int checks = 0, errors = 0;
  vec_t vecs[9];
  always #5 clk = ~clk;
  assign k_ready_i     = lat0 ? k_out_ready_o : kr;
  assign k_out_valid_i = lat0 ? k_valid_o : kv;
  assign k_out_data_i  = lat0 ? (k_data_o ^ KEY) : kd;
  sobel_mdc_frame_ctrl #(.DATA_WIDTH(32), .DIM_WIDTH(16), .ID_WIDTH(8), .CFG_CYCLES(CFG), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .width_i(width_i), .height_i(height_i), .cfg_id_i(cfg_id_i),
    .busy_o(busy_o), .done_o(done_o), .error_o(error_o), .cfg_id_o(cfg_id_o),
    .in_data_i(in_data_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .k_data_o(k_data_o), .k_valid_o(k_valid_o), .k_ready_i(k_ready_i),
    .k_out_data_i(k_out_data_i), .k_out_valid_i(k_out_valid_i), .k_out_ready_o(k_out_ready_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_last_o(out_last_o)
  );
  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic run_frame(input int idx, input vec_t v);
    int cyc = 0, n_in = 0, n_out = 0, n_kin = 0, first_in = -1, last_out = -1, done_cyc = -1, err_cyc = -1;
    int n_done = 0, n_err = 0, n_busy = 0, saw_rdy = 0, saw_ov = 0, idbad = 0;
    bit fin = 0, cleared = 0;
    logic [31:0] base = 32'(32'h1000 * (idx + 1));
    logic [31:0] kq[$];
    int kt[$];
    int total = v.w * v.h;
    lat0 = v.lat == 0;
    while (!fin && cyc < 300) begin
      start_i     = cyc == 0 || cyc == v.stray_at;
      width_i     = cyc == v.stray_at ? 16'd1 : 16'(v.w);
      height_i    = cyc == v.stray_at ? 16'd1 : 16'(v.h);
      cfg_id_i    = cyc == v.stray_at ? 8'hEE : 8'(v.id);
      clear_i     = !cleared && v.clr_at >= 0 && n_in == v.clr_at;
      in_valid_i  = !clear_i;
      in_data_i   = base + 32'(n_in);
      kr          = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready_i = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      kv          = kq.size() > 0 && kt[0] <= cyc;
      kd          = kv ? kq[0] : 32'h0;
      #1;
      if (cleared) begin
        chk("clear_outputs", {busy_o, done_o, error_o, in_ready_o, k_valid_o, k_out_ready_o, out_valid_o, out_last_o}, 0);
        fin = 1;
      end else begin
        if (cyc >= 1 && cfg_id_o !== 8'(v.id)) idbad++;
        n_busy  += int'(busy_o);
        saw_rdy += int'(in_ready_o);
        saw_ov  += int'(out_valid_o);
        if (done_o) begin n_done++; done_cyc = cyc; fin = 1; end
        if (error_o) begin n_err++; err_cyc = cyc; fin = 1; end
        if (in_valid_i && in_ready_o) begin
          if (first_in < 0) first_in = cyc;
          n_in++;
        end
        if (!lat0 && k_valid_o && k_ready_i) begin
          if (!(v.drop && n_kin == total - 1)) begin
            kq.push_back(k_data_o ^ KEY);
            kt.push_back(cyc + v.lat);
          end
          n_kin++;
        end
        if (!lat0 && k_out_valid_i && k_out_ready_o) begin
          void'(kq.pop_front());
          void'(kt.pop_front());
        end
        if (out_valid_o && out_ready_i) begin
          chk("out_data", out_data_o, (base + 32'(n_out)) ^ KEY);
          chk("out_last", longint'(out_last_o), longint'(n_out == total - 1));
          last_out = cyc;
          n_out++;
        end
        if (clear_i) cleared = 1;
        @(posedge clk); #1;
        cyc++;
      end
    end
    start_i = 0;
    clear_i = 0;
    chk("in_beats", n_in, v.exp_in);
    chk("out_beats", n_out, v.exp_out);
    chk("done_pulses", n_done, v.exp_done);
    chk("cfg_id_hold", idbad, 0);
    if (v.exp_busy >= 0) chk("busy_cycles", n_busy, v.exp_busy);
    if (v.exp_done > 0) chk("done_cycle", done_cyc, v.exp_out == 0 ? 1 : last_out + 1);
    if (!v.bp && v.exp_in > 0) chk("first_in", first_in, CFG + 1);
    if (v.exp_in == 0) begin
      chk("zero_in_ready", saw_rdy, 0);
      chk("zero_out_valid", saw_ov, 0);
    end
`ifdef SOBEL_MDC_CTRL_TIMEOUT_EN
    chk("error_pulses", n_err, v.drop ? 1 : 0);
    if (v.drop) chk("error_cycle", err_cyc, last_out + 16);
    if (!cleared) chk("post_busy_done", {busy_o, done_o}, 0);
`else
    chk("error_pulses", n_err, 0);
    if (!cleared) chk("post_busy_done", {busy_o, done_o}, v.drop ? 2 : 0);
`endif
    clear_i = v.drop;
    in_valid_i = 0;
    @(posedge clk); #1;
    clear_i = 0;
  endtask
  initial begin
    vecs[0] = '{4, 3, 5, 3, 1'b0, -1, -1, 1'b0, 12, 12, 1, 18};
    vecs[1] = '{4, 3, 9, 3, 1'b1, -1, -1, 1'b0, 12, 12, 1, -1};
    vecs[2] = '{0, 7, 3, 3, 1'b0, -1, -1, 1'b0, 0, 0, 1, 1};
    vecs[3] = '{4, 3, 4, 3, 1'b0, 5, -1, 1'b0, 5, 3, 0, 8};
    vecs[4] = '{4, 3, 5, 3, 1'b0, -1, -1, 1'b0, 12, 12, 1, 18};
    vecs[5] = '{4, 3, 6, 3, 1'b0, -1, 6, 1'b0, 12, 12, 1, 18};
    vecs[6] = '{1, 1, 7, 0, 1'b0, -1, -1, 1'b0, 1, 1, 1, 4};
    vecs[7] = '{3, 2, 2, 1, 1'b1, -1, -1, 1'b0, 6, 6, 1, -1};
    vecs[8] = '{4, 3, 8, 3, 1'b0, -1, -1, 1'b1, 12, 11, 0, -1};
    in_valid_i = 1; kr = 1; kv = 1; out_ready_i = 1; start_i = 1;
    width_i = 4; height_i = 3; cfg_id_i = 8'h55;
    #12;
    chk("reset_outputs", {busy_o, done_o, error_o, in_ready_o, k_valid_o, k_out_ready_o, out_valid_o, out_last_o}, 0);
    chk("reset_cfg_id", cfg_id_o, 0);
    @(negedge clk);
    start_i = 0;
    rst_ni = 1;
    @(posedge clk); #1;
    chk("idle_gating", {busy_o, in_ready_o, k_valid_o, k_out_ready_o, out_valid_o}, 0);
    in_valid_i = 0; kv = 0;
    for (int i = 0; i < 9; i++) run_frame(i, vecs[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
